// File: rtl/ad_pkg.sv
// Shared constants and types for the AD sample sequencer: source modes,
// sequencer state encoding and sample width.
package ad_pkg;

  localparam int AD_DW = 24;

  localparam logic [7:0] AD_TP_OFF   = 8'd0;
  localparam logic [7:0] AD_TP_CONST = 8'd1;
  localparam logic [7:0] AD_TP_RAMP  = 8'd2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TICK = 2'd1,
    ST_CONV      = 2'd2,
    ST_WAIT_RDY  = 2'd3
  } ad_state_e;

  function automatic logic [7:0] ad_sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ad_seq_if.sv
// ADC convert/ready handshake plus the valid/ready sample stream.
// AD_SEQ_SEQNUM_EN adds the smp_seq sequence-number field.
interface ad_seq_if;
  import ad_pkg::*;

  logic             ad_cnv;
  logic             ad_rdy;
  logic [AD_DW-1:0] ad_data;
  logic [AD_DW-1:0] smp_data;
  logic             smp_vld;
  logic             smp_rdy;
`ifdef AD_SEQ_SEQNUM_EN
  logic [7:0]       smp_seq;

  modport master (
    output ad_cnv, input ad_rdy, input ad_data,
    output smp_data, output smp_vld, input smp_rdy, output smp_seq
  );
  modport slave (
    input ad_cnv, output ad_rdy, output ad_data,
    input smp_data, input smp_vld, output smp_rdy, input smp_seq
  );
`else
  modport master (
    output ad_cnv, input ad_rdy, input ad_data,
    output smp_data, output smp_vld, input smp_rdy
  );
  modport slave (
    input ad_cnv, output ad_rdy, output ad_data,
    input smp_data, input smp_vld, output smp_rdy
  );
`endif

endinterface

// File: rtl/ad_tick_gen.sv
// Sample-period tick: prescaler of TICK_DIV cycles times a period counter of
// P units, P latched at clear and at every tick (0 treated as 1).
module ad_tick_gen #(
  parameter int TICK_DIV = 100
) (
  input  logic       clk_sys,
  input  logic       rst,
  input  logic       clr,
  input  logic [7:0] period,
  output logic       tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    unit_q, unit_d;
  logic [7:0]    per_q, per_d;
  logic [7:0]    per_eff;
  logic          presc_wrap;
  logic          unit_wrap;

  assign per_eff    = (per_q == 8'd0) ? 8'd1 : per_q;
  assign presc_wrap = (presc_q == PW'(TICK_DIV - 1));
  assign unit_wrap  = (unit_q == per_eff - 8'd1);
  assign tick       = !clr && presc_wrap && unit_wrap;

  always_comb begin
    presc_d = presc_q;
    unit_d  = unit_q;
    per_d   = per_q;
    if (clr) begin
      presc_d = '0;
      unit_d  = '0;
      per_d   = period;
    end else begin
      if (presc_wrap) begin
        presc_d = '0;
        unit_d  = unit_wrap ? 8'd0 : unit_q + 8'd1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
      // New period only applies once the running one has fully elapsed.
      if (tick) per_d = period;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      presc_q <= '0;
      unit_q  <= '0;
      per_q   <= '0;
    end else begin
      presc_q <= presc_d;
      unit_q  <= unit_d;
      per_q   <= per_d;
    end
  end

endmodule

// File: rtl/ad_seq.sv
// AD sample sequencer: paces ADC conversions or test patterns onto a
// valid/ready sample stream. AD_SEQ_SEQNUM_EN enables the smp_seq counter.
module ad_seq
  import ad_pkg::*;
#(
  parameter int TICK_DIV = 100,
  parameter int TMO_CYC  = 255
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             run,
  input  logic [7:0]       cfg_sample,
  input  logic [7:0]       cfg_ad_tp,
  input  logic [AD_DW-1:0] cfg_tp_base,
  input  logic [7:0]       cfg_tp_step,
  ad_seq_if.master         bus,
  output logic             stat_busy,
  output logic [7:0]       stat_ovf_cnt,
  output logic             stat_tmo
);

  localparam int TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

  ad_state_e        state_q, state_d;
  logic             run_q;
  logic [7:0]       mode_q, mode_d;
  logic [AD_DW-1:0] acc_q, acc_d;
  logic [AD_DW-1:0] smp_data_q, smp_data_d;
  logic             smp_vld_q, smp_vld_d;
  logic             ad_cnv_q, ad_cnv_d;
  logic [7:0]       ovf_q, ovf_d;
  logic             tmo_q, tmo_d;
  logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic             load_en;
  logic [AD_DW-1:0] load_val;
  logic             tick;
  logic             slot_busy;
`ifdef AD_SEQ_SEQNUM_EN
  logic [7:0]       seq_q, seq_d;
`endif

  ad_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_sys (clk_sys),
    .rst     (rst),
    .clr     (state_q == ST_IDLE),
    .period  (cfg_sample),
    .tick    (tick)
  );

  assign slot_busy = smp_vld_q && !bus.smp_rdy;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    tmo_d      = tmo_q;
    tmo_cnt_d  = tmo_cnt_q;
    ad_cnv_d   = 1'b0;
    smp_data_d = smp_data_q;
    smp_vld_d  = smp_vld_q && !bus.smp_rdy;
    load_en    = 1'b0;
    load_val   = '0;
`ifdef AD_SEQ_SEQNUM_EN
    seq_d      = seq_q;
`endif

    if (tick) mode_d = cfg_ad_tp;

    unique case (state_q)
      ST_IDLE: begin
        if (run && !run_q) begin
          tmo_d   = 1'b0;
          ovf_d   = '0;
          acc_d   = cfg_tp_base;
          mode_d  = cfg_ad_tp;
          state_d = ST_WAIT_TICK;
`ifdef AD_SEQ_SEQNUM_EN
          seq_d   = '0;
`endif
        end
      end
      ST_WAIT_TICK: begin
        if (!run) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (slot_busy) begin
            ovf_d = ad_sat_inc(ovf_q);
          end else if (mode_q == AD_TP_CONST) begin
            load_en  = 1'b1;
            load_val = cfg_tp_base;
          end else if (mode_q == AD_TP_RAMP) begin
            load_en  = 1'b1;
            load_val = acc_q;
            acc_d    = acc_q + {{(AD_DW-8){1'b0}}, cfg_tp_step};
          end else begin
            ad_cnv_d = 1'b1;
            state_d  = ST_CONV;
          end
        end
      end
      ST_CONV: begin
        if (tick) ovf_d = ad_sat_inc(ovf_q);
        tmo_cnt_d = '0;
        state_d   = ST_WAIT_RDY;
      end
      ST_WAIT_RDY: begin
        if (tick) ovf_d = ad_sat_inc(ovf_q);
        if (bus.ad_rdy) begin
          load_en  = 1'b1;
          load_val = bus.ad_data;
          state_d  = run ? ST_WAIT_TICK : ST_IDLE;
        end else if (tmo_cnt_q == TW'(TMO_CYC - 1)) begin
          tmo_d   = 1'b1;
          state_d = run ? ST_WAIT_TICK : ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new sample may load on the same edge the previous one is accepted.
    if (load_en) begin
      smp_data_d = load_val;
      smp_vld_d  = 1'b1;
`ifdef AD_SEQ_SEQNUM_EN
      seq_d      = seq_q + 8'd1;
`endif
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      run_q      <= 1'b0;
      mode_q     <= '0;
      acc_q      <= '0;
      smp_data_q <= '0;
      smp_vld_q  <= 1'b0;
      ad_cnv_q   <= 1'b0;
      ovf_q      <= '0;
      tmo_q      <= 1'b0;
      tmo_cnt_q  <= '0;
`ifdef AD_SEQ_SEQNUM_EN
      seq_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      run_q      <= run;
      mode_q     <= mode_d;
      acc_q      <= acc_d;
      smp_data_q <= smp_data_d;
      smp_vld_q  <= smp_vld_d;
      ad_cnv_q   <= ad_cnv_d;
      ovf_q      <= ovf_d;
      tmo_q      <= tmo_d;
      tmo_cnt_q  <= tmo_cnt_d;
`ifdef AD_SEQ_SEQNUM_EN
      seq_q      <= seq_d;
`endif
    end
  end

  assign bus.ad_cnv   = ad_cnv_q;
  assign bus.smp_data = smp_data_q;
  assign bus.smp_vld  = smp_vld_q;
`ifdef AD_SEQ_SEQNUM_EN
  assign bus.smp_seq  = seq_q;
`endif
  assign stat_busy    = (state_q != ST_IDLE);
  assign stat_ovf_cnt = ovf_q;
  assign stat_tmo     = tmo_q;

endmodule

// File: tb/tb_ad_seq.sv
// Directed bench for ad_seq with TICK_DIV = 4 and an ADC responder model;
// sample period 3 gives 12-cycle ticks.
module tb_ad_seq;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic        run;
  logic [7:0]  cfg_sample;
  logic [7:0]  cfg_ad_tp;
  logic [23:0] cfg_tp_base;
  logic [7:0]  cfg_tp_step;
  logic        stat_busy;
  logic [7:0]  stat_ovf_cnt;
  logic        stat_tmo;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // ADC model controls
  bit adc_en  = 1'b0;
  int adc_dly = 5;
  int adc_n   = 0;
  localparam logic [23:0] ADC_BASE = 24'hA50000;

  ad_seq_if bus();

  ad_seq #(.TICK_DIV(4), .TMO_CYC(255)) dut (
    .clk_sys      (clk_sys),
    .rst          (rst),
    .run          (run),
    .cfg_sample   (cfg_sample),
    .cfg_ad_tp    (cfg_ad_tp),
    .cfg_tp_base  (cfg_tp_base),
    .cfg_tp_step  (cfg_tp_step),
    .bus          (bus),
    .stat_busy    (stat_busy),
    .stat_ovf_cnt (stat_ovf_cnt),
    .stat_tmo     (stat_tmo)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("  ok %s = %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_cnv(input string tag, input int max, output int at);
    bit seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      step();
      if (bus.ad_cnv) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd1);
    at = cyc;
  endtask

  task automatic wait_vld(input string tag, input int max, output int at);
    bit seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      step();
      if (bus.smp_vld) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd1);
    at = cyc;
  endtask

  task automatic stop_run();
    run = 1'b0;
    repeat (3) step();
    check("stop_busy", 32'(stat_busy), 32'd0);
  endtask

  // ADC responder: ad_rdy pulses adc_dly cycles after the ad_cnv cycle
  initial begin
    bus.ad_rdy  = 1'b0;
    bus.ad_data = '0;
    forever begin
      step();
      if (bus.ad_cnv && adc_en) begin
        repeat (adc_dly) step();
        bus.ad_rdy  = 1'b1;
        bus.ad_data = ADC_BASE + 24'(adc_n);
        adc_n++;
        step();
        bus.ad_rdy = 1'b0;
      end
    end
  end

  initial begin
    int t0, t1, t_prev, n, bad, cnt;
    logic [23:0] ramp_exp [3];
    int gap_exp [3];
    ramp_exp[0] = 24'hFFFFFE; ramp_exp[1] = 24'h000001; ramp_exp[2] = 24'h000004;
    gap_exp[0] = 12; gap_exp[1] = 4; gap_exp[2] = 4;

    rst = 1'b1; run = 1'b0; bus.smp_rdy = 1'b0;
    cfg_sample = 8'd3; cfg_ad_tp = 8'd0; cfg_tp_base = '0; cfg_tp_step = '0;
    repeat (3) step();
    check("rst_vld",  32'(bus.smp_vld), 32'd0);
    check("rst_cnv",  32'(bus.ad_cnv), 32'd0);
    check("rst_data", 32'(bus.smp_data), 32'd0);
    check("rst_busy", 32'(stat_busy), 32'd0);
    check("rst_ovf",  32'(stat_ovf_cnt), 32'd0);
    check("rst_tmo",  32'(stat_tmo), 32'd0);
    rst = 1'b0;
    step();

    // 1: ADC mode, conversions every 12 cycles, data one cycle after ad_rdy
    adc_en = 1'b1; adc_dly = 5; bus.smp_rdy = 1'b1; cfg_ad_tp = 8'd0;
    run = 1'b1;
    t_prev = cyc;
    for (int k = 0; k < 3; k++) begin
      wait_cnv("t1_cnv_seen", 40, t1);
      check(k == 0 ? "t1_first_lat" : "t1_gap", 32'(t1 - t_prev), k == 0 ? 32'd13 : 32'd12);
      t_prev = t1;
      step();
      check("t1_cnv_pulse", 32'(bus.ad_cnv), 32'd0);
      wait_vld("t1_vld_seen", 20, n);
      check("t1_vld_lat", 32'(n - t1), 32'd6);
      check("t1_data", 32'(bus.smp_data), 32'(ADC_BASE + 24'(k)));
    end
    check("t1_ovf", 32'(stat_ovf_cnt), 32'd0);
    stop_run();

    // 2: ramp mode wrapping modulo 2^24
    adc_en = 1'b0; cfg_ad_tp = 8'd2; cfg_tp_base = 24'hFFFFFE; cfg_tp_step = 8'd3;
    run = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_vld("t2_vld_seen", 20, n);
      check("t2_data", 32'(bus.smp_data), 32'(ramp_exp[k]));
`ifdef AD_SEQ_SEQNUM_EN
      check("t2_seq", 32'(bus.smp_seq), 32'(k + 1));
`endif
    end
    stop_run();

    // 3: constant mode with a stalled consumer
    cfg_ad_tp = 8'd1; cfg_tp_base = 24'h123456; bus.smp_rdy = 1'b0;
    run = 1'b1;
    wait_vld("t3_vld_seen", 20, n);
    check("t3_data", 32'(bus.smp_data), 32'h123456);
    bad = 0;
    repeat (40) begin
      step();
      if (!bus.smp_vld || bus.smp_data !== 24'h123456) bad++;
    end
    check("t3_hold", 32'(bad), 32'd0);
    check("t3_ovf", 32'(stat_ovf_cnt), 32'd3);
    bus.smp_rdy = 1'b1;
    step();
    check("t3_accept", 32'(bus.smp_vld), 32'd0);
    stop_run();

    // 4: ADC never answers -> timeout, next conversion at the following tick
    cfg_ad_tp = 8'd0; adc_en = 1'b0;
    run = 1'b1;
    wait_cnv("t4_cnv_seen", 40, t0);
    n = 0; cnt = 0;
    for (int i = 0; i < 400 && !stat_tmo; i++) begin
      step();
      n++;
      if (bus.smp_vld) cnt++;
    end
    check("t4_tmo_lat", 32'(n), 32'd256);
    check("t4_no_vld", 32'(cnt), 32'd0);
    wait_cnv("t4_cnv2_seen", 100, t1);
    check("t4_cnv_gap", 32'(t1 - t0), 32'd264);
    check("t4_ovf", 32'(stat_ovf_cnt), 32'd21);
    check("t4_tmo_sticky", 32'(stat_tmo), 32'd1);
    run = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check("t4_rst_tmo", 32'(stat_tmo), 32'd0);

    // 5: period change mid-period takes effect after the current period
    cfg_ad_tp = 8'd2; cfg_tp_base = 24'h000010; cfg_tp_step = 8'd1; cfg_sample = 8'd3;
    run = 1'b1;
    wait_vld("t5_vld_seen", 20, t_prev);
    check("t5_data0", 32'(bus.smp_data), 32'h10);
    repeat (5) step();
    cfg_sample = 8'd1;
    for (int k = 0; k < 3; k++) begin
      wait_vld("t5_vld_seen", 20, t1);
      check("t5_gap", 32'(t1 - t_prev), 32'(gap_exp[k]));
      check("t5_data", 32'(bus.smp_data), 32'(24'h10 + 24'(k + 1)));
      t_prev = t1;
    end
    stop_run();

    // 6a: run dropped during WAIT_RDY, conversion still completes
    cfg_sample = 8'd3; cfg_ad_tp = 8'd0; adc_en = 1'b1; adc_dly = 5; bus.smp_rdy = 1'b0;
    run = 1'b1;
    wait_cnv("t6_cnv_seen", 40, t0);
    repeat (3) step();
    run = 1'b0;
    wait_vld("t6_vld_seen", 10, t1);
    check("t6_vld_lat", 32'(t1 - t0), 32'd6);
    check("t6_data", 32'(bus.smp_data), 32'(ADC_BASE + 24'd3));
    check("t6_idle", 32'(stat_busy), 32'd0);
    cnt = 0; bad = 0;
    repeat (30) begin
      step();
      if (bus.ad_cnv) cnt++;
      if (!bus.smp_vld) bad++;
    end
    check("t6_no_cnv", 32'(cnt), 32'd0);
    check("t6_pending", 32'(bad), 32'd0);
    bus.smp_rdy = 1'b1;
    step();
    check("t6_accept", 32'(bus.smp_vld), 32'd0);

    // 6b: reset in the middle of WAIT_RDY
    adc_en = 1'b0;
    run = 1'b1;
    wait_cnv("t6b_cnv_seen", 40, t0);
    repeat (30) step();
    check("t6b_busy", 32'(stat_busy), 32'd1);
    check("t6b_ovf", 32'(stat_ovf_cnt), 32'd2);
    rst = 1'b1;
    step();
    check("t6b_rst_busy", 32'(stat_busy), 32'd0);
    check("t6b_rst_ovf", 32'(stat_ovf_cnt), 32'd0);
    check("t6b_rst_vld", 32'(bus.smp_vld), 32'd0);
    check("t6b_rst_data", 32'(bus.smp_data), 32'd0);
    check("t6b_rst_cnv", 32'(bus.ad_cnv), 32'd0);
    rst = 1'b0; run = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
